// File: rtl/unary_pkg.sv
// Shared definitions for the temporal-unary datapath.
// udec_state_t is the frame-state encoding used by the decoder. The encoder
// side uses the same names, so frame states read the same on both ends.
// max_len_ok() checks at elaboration time that a WIDTH-bit count can hold a
// full frame of ones.
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } udec_state_t;

  function automatic bit max_len_ok(input int width, input int max_len);
    return (max_len >= 1) && (max_len <= (2 ** width) - 1);
  endfunction

endpackage

// File: rtl/unary_frame_counter.sv
// Per-frame accumulator for the unary stream decoder.
// Keeps the ones count, the beat length, a "seen a zero" flag and an
// ordering-fault flag (a 1 arrived after a 0).
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   en              a beat is accepted this cycle; commit the next values
//   clr             this beat starts a frame, so accumulate from zero
//   bit_in          unary stream bit of the current beat
//   count_nxt       ones count including the current beat
//   len_nxt         beat count including the current beat
//   ordr_nxt        ordering fault including the current beat
// The *_nxt values are combinational. The owner can capture the final
// totals on the same edge that accepts the last beat.
module unary_frame_counter
  import unary_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] count_nxt,
  output logic [LEN_W-1:0] len_nxt,
  output logic             ordr_nxt
);

  logic [WIDTH-1:0] count;
  logic [LEN_W-1:0] len;
  logic             seen0;
  logic             ordr;
  logic             seen0_nxt;

  // On the first beat of a frame, the stored values are treated as zero.
  // This lets a new frame start without spending a cycle on a clear.
  always_comb begin
    count_nxt = (clr ? '0 : count) + WIDTH'(bit_in);
    len_nxt   = (clr ? '0 : len) + LEN_W'(1);
    seen0_nxt = (clr ? 1'b0 : seen0) | ~bit_in;
    ordr_nxt  = clr ? 1'b0 : (ordr | (seen0 & bit_in));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      len   <= '0;
      seen0 <= 1'b0;
      ordr  <= 1'b0;
    end else if (en) begin
      count <= count_nxt;
      len   <= len_nxt;
      seen0 <= seen0_nxt;
      ordr  <= ordr_nxt;
    end
  end

endmodule

// File: rtl/unary_stream_decoder.sv
// Decodes a serial thermometer-coded unary stream (one bit per beat) into a
// binary count of ones. It also flags ordering faults (a 1 after a 0) and
// frames that reach MAX_LEN beats without last.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   valid      a beat is present on bit_in/last
//   bit_in     unary stream bit
//   last       final beat of the frame (qualified by valid)
//   accept     decoder takes a beat this cycle (low while a result is held)
//   ack        consumer has taken the result (qualified by ready)
//   ready      out/err_* hold a finished frame
//   out        decoded count of ones
//   err_order  frame was not thermometer-ordered
//   err_len    frame hit MAX_LEN beats without last
module unary_stream_decoder
  import unary_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             bit_in,
  input  logic             last,
  output logic             accept,
  input  logic             ack,
  output logic             ready,
  output logic [WIDTH-1:0] out,
  output logic             err_order,
  output logic             err_len
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  if (!max_len_ok(WIDTH, MAX_LEN)) begin : g_bad_max_len
    $error("unary_stream_decoder: MAX_LEN must be in 1..2**WIDTH-1");
  end

  udec_state_t      state;
  logic             beat;
  logic             hit_max;
  logic [WIDTH-1:0] count_nxt;
  logic [LEN_W-1:0] len_nxt;
  logic             ordr_nxt;

  assign accept = (state != DONE);
  assign ready  = (state == DONE);
  assign beat   = valid & accept;

  unary_frame_counter #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .en        (beat),
    .clr       (state == IDLE),
    .bit_in    (bit_in),
    .count_nxt (count_nxt),
    .len_nxt   (len_nxt),
    .ordr_nxt  (ordr_nxt)
  );

  // The beat being accepted now would make the frame MAX_LEN long.
  assign hit_max = (len_nxt == LEN_W'(MAX_LEN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out       <= '0;
      err_order <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      case (state)
        IDLE, COUNT: begin
          if (beat) begin
            if (last || hit_max) begin
              state     <= DONE;
              out       <= count_nxt;
              err_order <= ordr_nxt;
              // If last and MAX_LEN arrive on the same beat, the frame is
              // treated as properly terminated.
              err_len   <= ~last;
            end else begin
              state <= COUNT;
            end
          end
        end
        DONE: begin
          if (ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
module tb_unary_stream_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic       bit_in;
  logic       last;
  logic       accept;
  logic       ack;
  logic       ready;
  logic [7:0] out;
  logic       err_order;
  logic       err_len;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int o;
    int eo;
    int el;
  } exp_t;

  exp_t exp_q[$];

  unary_stream_decoder #(.WIDTH(8), .MAX_LEN(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .bit_in    (bit_in),
    .last      (last),
    .accept    (accept),
    .ack       (ack),
    .ready     (ready),
    .out       (out),
    .err_order (err_order),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int o, input int eo, input int el);
    exp_t e;
    e.o  = o;
    e.eo = eo;
    e.el = el;
    exp_q.push_back(e);
  endtask

  // Inputs change on the falling edge, so the DUT sees them at the next rising edge.
  task automatic drive(input logic v, input logic b, input logic l);
    @(negedge clk);
    valid  = v;
    bit_in = b;
    last   = l;
  endtask

  task automatic send_frame(input logic [255:0] bits, input int n,
                            input bit set_last, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, bits[i], (set_last && i == n - 1));
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          drive(1'b0, 1'b0, 1'b0);
          chk("gap_ready", int'(ready), 0);
          chk("gap_accept", int'(accept), 1);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", int'(ready), 1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ready_after_ack", int'(ready), 0);
    chk("accept_after_ack", int'(accept), 1);
  endtask

  // Monitor: each time ready rises, compare the presented frame with the oldest expected frame.
  initial begin
    logic prev_ready;
    int   fr;
    exp_t e;
    prev_ready = 1'b0;
    fr = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("frame%0d_out", fr), int'(out), e.o);
          chk($sformatf("frame%0d_err_order", fr), int'(err_order), e.eo);
          chk($sformatf("frame%0d_err_len", fr), int'(err_len), e.el);
        end
        fr++;
      end
      prev_ready = ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] v;
    reset = 1'b1;
    valid = 1'b0;
    bit_in = 1'b0;
    last = 1'b0;
    ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_err_order", int'(err_order), 0);
    chk("rst_err_len", int'(err_len), 0);
    chk("rst_accept", int'(accept), 1);
    reset = 1'b0;
    @(negedge clk);

    // 1: 225 ones then 30 zeros, last on beat 255
    v = '0;
    for (int i = 0; i < 225; i++) v[i] = 1'b1;
    push_exp(225, 0, 0);
    send_frame(v, 255, 1'b1, 0);
    chk("t1_latency_ready", int'(ready), 1);
    wait_ready(20);
    do_ack();

    // ack while idle is ignored
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("idle_ack_ready", int'(ready), 0);
    chk("idle_ack_accept", int'(accept), 1);

    // 2: single-beat frame
    push_exp(1, 0, 0);
    v = '0;
    v[0] = 1'b1;
    send_frame(v, 1, 1'b1, 0);
    chk("t2_latency_ready", int'(ready), 1);
    wait_ready(20);
    do_ack();

    // single-beat frame of a zero
    push_exp(0, 0, 0);
    v = '0;
    send_frame(v, 1, 1'b1, 0);
    wait_ready(20);
    do_ack();

    // 3: 1,1,1,0,0 with 3-cycle gaps
    push_exp(3, 0, 0);
    v = '0;
    v[2:0] = 3'b111;
    send_frame(v, 5, 1'b1, 3);
    wait_ready(20);
    do_ack();

    // 4: 1,1,0,1,0 is out of order, then the clean frame 1,0
    push_exp(3, 1, 0);
    v = '0;
    v[4:0] = 5'b01011;
    send_frame(v, 5, 1'b1, 0);
    wait_ready(20);
    do_ack();
    push_exp(1, 0, 0);
    v = '0;
    v[1:0] = 2'b01;
    send_frame(v, 2, 1'b1, 0);
    wait_ready(20);
    do_ack();

    // 5: 255 ones without last, then beats offered while a result is held
    push_exp(255, 0, 1);
    v = '1;
    send_frame(v, 255, 1'b0, 0);
    chk("t5_accept_done", int'(accept), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      chk("t5_ignored_out", int'(out), 255);
      chk("t5_ignored_ready", int'(ready), 1);
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("t5_ignored_accept", int'(accept), 0);
    wait_ready(20);
    do_ack();

    // 6: result holds while ack stays low
    push_exp(4, 0, 0);
    v = '0;
    v[4:0] = 5'b01111;
    send_frame(v, 5, 1'b1, 0);
    wait_ready(20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_hold_out", int'(out), 4);
      chk("t6_hold_ready", int'(ready), 1);
    end
    do_ack();

    // reset after 40 beats of a frame discards it
    v = '1;
    send_frame(v, 40, 1'b0, 0);
    chk("t6_midframe_ready", int'(ready), 0);
    reset = 1'b1;
    #1;
    chk("t6_rst_out", int'(out), 0);
    chk("t6_rst_ready", int'(ready), 0);
    chk("t6_rst_accept", int'(accept), 1);
    @(negedge clk);
    reset = 1'b0;
    push_exp(2, 0, 0);
    v = '0;
    v[2:0] = 3'b011;
    send_frame(v, 3, 1'b1, 0);
    wait_ready(20);
    do_ack();

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
